// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the iterative
// multiply/divide unit.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] src1_i;
  logic [XLEN-1:0] src2_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, src1_i, src2_i, flush_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, src1_i, src2_i, flush_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign correction applied on completion.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic     clk_i,
  input  logic     rst_i,
  muldiv_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic              neg_q, neg_r;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] acc, acc_nxt, acc_mul, acc_div, full;
  logic [XLEN-1:0]   result_q, res_nxt, special_res, abs1, abs2, quo, rem;
  logic [XLEN:0]     sum, r_sh, diff;
  logic              s1_signed, s2_signed, s1_neg, s2_neg;
  logic              div_zero, div_ovf, special, accept, ge;

  assign bus.busy_o   = (state == CALC);
  assign bus.done_o   = (state == FINISH);
  assign bus.result_o = result_q;

  // Operand decode and the single-cycle special cases, evaluated at accept.
  always_comb begin
    s1_signed = 1'b0;
    s2_signed = 1'b0;
    case (bus.op_i)
      3'b001, 3'b100, 3'b110: begin s1_signed = 1'b1; s2_signed = 1'b1; end
      3'b010:                 s1_signed = 1'b1;
      default: ;
    endcase
    s1_neg   = s1_signed & bus.src1_i[XLEN-1];
    s2_neg   = s2_signed & bus.src2_i[XLEN-1];
    abs1     = s1_neg ? -bus.src1_i : bus.src1_i;
    abs2     = s2_neg ? -bus.src2_i : bus.src2_i;
    div_zero = bus.op_i[2] && (bus.src2_i == '0);
    div_ovf  = bus.op_i[2] && !bus.op_i[0] && (bus.src1_i == MIN_VAL) && (bus.src2_i == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = bus.op_i[1] ? bus.src1_i : '1;
    else          special_res = bus.op_i[1] ? '0 : bus.src1_i;
    accept   = (state == IDLE) && bus.start_i && !bus.flush_i;
  end

  // One iteration; acc holds {product} for multiply and {rem, quo} for divide.
  always_comb begin
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
    acc_mul = {sum, acc[XLEN-1:1]};
    r_sh    = acc[2*XLEN-1:XLEN-1];
    diff    = r_sh - {1'b0, b_q};
    ge      = (r_sh >= {1'b0, b_q});
    acc_div = {(ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0]), acc[XLEN-2:0], ge};
    acc_nxt = op_q[2] ? acc_div : acc_mul;
  end

  // Final result is taken from the last iteration's output so it can be
  // registered on the same edge that enters FINISH.
  always_comb begin
    full = neg_q ? -acc_nxt : acc_nxt;
    quo  = acc_nxt[XLEN-1:0];
    rem  = acc_nxt[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 res_nxt = full[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_nxt = full[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res_nxt = neg_q ? -quo : quo;
      default:                res_nxt = neg_r ? -rem : rem;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? FINISH : CALC;
      CALC:    if (cnt == CNT_W'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_q      <= '0;
      acc      <= '0;
      result_q <= '0;
    end else if (accept) begin
      cnt   <= CNT_W'(XLEN);
      op_q  <= bus.op_i;
      neg_q <= s1_neg ^ s2_neg;
      neg_r <= s1_neg;
      b_q   <= abs2;
      acc   <= {{XLEN{1'b0}}, abs1};
      if (special) result_q <= special_res;
    end else if (bus.flush_i) begin
      cnt <= '0;
    end else if (state == CALC) begin
      acc <= acc_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) result_q <= res_nxt;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, handshake/abort
// scenarios and randomized operations against a 64-bit arithmetic model.
module tb_muldiv_unit;
  localparam logic [31:0] MIN_VAL = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [31:0] last_exp = '0;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_VAL && b == 32'hFFFF_FFFF) return MIN_VAL;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_VAL && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Called at posedge+1 in an idle cycle. intr: cycle to inject an ignored
  // start; fl: cycle to assert flush (0 disables either).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int intr, input int fl);
    int n;
    int busy_cnt;
    bit seen;
    bit special;
    special = op[2] && (b == 0 || (!op[0] && a == MIN_VAL && b == 32'hFFFF_FFFF));
    bus.op_i = op; bus.src1_i = a; bus.src2_i = b; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.op_i = 3'($urandom); bus.src1_i = $urandom; bus.src2_i = $urandom;
    busy_cnt = 0;
    seen = 1'b0;
    for (n = 1; n <= 40; n++) begin
      if (n == intr) begin
        bus.start_i = 1'b1;
        bus.op_i = 3'($urandom); bus.src1_i = $urandom; bus.src2_i = $urandom;
      end else bus.start_i = 1'b0;
      bus.flush_i = (n == fl);
      if (fl != 0 && n == fl + 1) check("flush_busy", 64'(bus.busy_o), 64'(0));
      if (bus.busy_o) busy_cnt++;
      if (bus.done_o) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    if (fl == 0) begin
      check($sformatf("lat op%0d", op), 64'(n), special ? 64'(1) : 64'(33));
      check($sformatf("busy op%0d", op), 64'(busy_cnt), special ? 64'(0) : 64'(32));
      check($sformatf("res op%0d %h/%h", op, a, b), 64'(bus.result_o), 64'(exp));
      last_exp = exp;
    end else begin
      check("flush_nodone", 64'(seen), 64'(0));
      check("flush_hold", 64'(bus.result_o), 64'(last_exp));
    end
    @(posedge clk); #1;
    check("done_pulse", 64'(bus.done_o), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pool [6];
    logic [31:0] a, b;
    logic [2:0]  op;
    bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.op_i = '0;
    bus.src1_i = '0; bus.src2_i = '0;
    #12;
    check("rst_busy", 64'(bus.busy_o), 64'(0));
    check("rst_done", 64'(bus.done_o), 64'(0));
    check("rst_res", 64'(bus.result_o), 64'(0));
    #2 rst = 1'b0;
    @(posedge clk); #1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 0, 0);
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 0, 0);
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd6, 32'd5, 32'd0, 32'd5, 0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 0);

    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 5, 0);
    run_op(3'd0, 32'd1234, 32'd5678, 32'd0, 0, 10);

    // start and flush together in IDLE: nothing accepted
    bus.op_i = 3'd0; bus.src1_i = 32'd9; bus.src2_i = 32'd9;
    bus.start_i = 1'b1; bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    check("sf_busy", 64'(bus.busy_o), 64'(0));
    check("sf_done", 64'(bus.done_o), 64'(0));
    @(posedge clk); #1;
    check("sf_done2", 64'(bus.done_o), 64'(0));
    check("sf_res", 64'(bus.result_o), 64'(last_exp));

    pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF;
    pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 120; i++) begin
      op = 3'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 30);
      run_op(op, a, b, ref_model(op, a, b), 0, 0);
    end

    // asynchronous reset in the middle of a multiply
    bus.op_i = 3'd0; bus.src1_i = $urandom; bus.src2_i = $urandom; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (16) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", 64'(bus.busy_o), 64'(0));
    check("arst_done", 64'(bus.done_o), 64'(0));
    check("arst_res", 64'(bus.result_o), 64'(0));
    last_exp = '0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at parametrised width. It sits beside the existing single-cycle ALU in the execute stage. The core stalls PC update while busy_o is high and writes result_o to rd when done_o pulses. It is the multi-cycle successor to the combinational ALU: operand capture, a shift-add/restoring-divide datapath, a start/done handshake, and abort support.

Parameters:
XLEN, 32, operand/result width in bits; any value ≥4.
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset, asynchronous, active-high
start_i  input  1  request; accepted only in IDLE
op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src1_i  input  XLEN  rs1 value (multiplicand/dividend)
src2_i  input  XLEN  rs2 value (multiplier/divisor)
flush_i  input  1  abort the current operation
busy_o  output  1  high while an accepted operation is in progress
done_o  output  1  one-cycle completion pulse
result_o  output  XLEN  result; valid when done_o=1 and held until the next accepted start

Behaviour:
- Reset (async, rst_i=1): state=IDLE, counter=0, busy_o=0, done_o=0, result_o=0, all internal registers cleared. Reset mid-operation discards the operation and produces no done_o.
- FSM states: IDLE, CALC, FINISH.
  - IDLE -> CALC on start_i=1, normal case.
  - IDLE -> FINISH on start_i=1, special case: divide by zero, or signed overflow.
  - CALC -> FINISH when the counter reaches 0 after the last iteration.
  - FINISH -> IDLE unconditionally.
- Accept edge: latch op_i, sign flags, |src1|, |src2|, and result sign. Set counter=XLEN. Drive busy_o=1 from the next cycle.
- Operand signedness:
  - src1 is signed for MULH, MULHSU, DIV, REM.
  - src2 is signed for MULH, DIV, REM.
  - MUL takes the low half, which is sign-independent; it is computed unsigned.
- CALC: one iteration per cycle, XLEN iterations. Counter decrements each cycle.
  - Multiply: radix-2 shift-add into a 2*XLEN product register.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FINISH: apply sign correction and select the result. Drive done_o=1 and busy_o=0, and register result_o.
  - Product sign = s1 XOR s2; low or high half selected by op.
  - Quotient sign = s1 XOR s2.
  - Remainder sign = sign of dividend.
- Latency: done_o is high in the cycle after XLEN+1 rising edges following the accept edge (33 cycles for XLEN=32). Special cases take 1 cycle: done_o is high in the cycle immediately after the accept edge.
- Special cases (RISC-V spec):
  - Divisor=0: DIV/DIVU give quotient=all ones; REM/REMU give remainder=src1.
  - DIV/REM of 2^(XLEN-1) by -1: quotient=2^(XLEN-1), remainder=0.
- start_i while busy_o=1 or in FINISH: ignored, with no effect on the operation in progress. Back-to-back use: start_i may be asserted in the cycle after done_o, when the FSM is back in IDLE.
- flush_i=1 in any cycle:
  - FSM -> IDLE at the next edge; no done_o; result_o keeps its previous value.
  - flush_i takes priority over start_i in the same cycle, so no operation is accepted.
- Operand inputs are sampled only at the accept edge; later changes to them are ignored.
- All arithmetic is modulo 2^XLEN per half. No exceptions are raised.

Test Plan:
- Start MUL, src1=7, src2=0xFFFFFFFD -> busy_o=1 for 32 cycles; done_o pulses 33 cycles after accept; result_o=0xFFFFFFEB.
- High-half multiplies -> required results:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide of -7 by 2 -> DIV gives 0xFFFFFFFD; REM gives 0xFFFFFFFF; DIVU 100/7 gives 14; REMU 100/7 gives 2.
- Special cases -> done_o one cycle after accept:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> 0.
- Handshake and abort:
  - Start DIV, then pulse start_i with new operands at cycle 5 -> ignored; original result produced.
  - Start MUL, then flush_i at cycle 10 -> no done_o; busy_o=0 next cycle; result_o unchanged.
  - Simultaneous start_i and flush_i in IDLE -> not accepted.
- Assert rst_i asynchronously mid-CALC (cycle 17) -> busy_o, done_o, and result_o go to 0 immediately. A fresh MUL 3×4 after reset release returns 12 with the nominal 33-cycle latency.
